// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared definitions for the issue-side hazard controller: opcodes, the NOP word,
// FSM encoding and the decoded-field bundle.
package hazard_issue_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1
  } state_e;

  typedef struct packed {
    logic       writes;
    logic [4:0] dest;
    logic       rs_used;
    logic       rt_used;
    logic       is_branch;
  } fields_t;

  // 5-bit register compare cell: $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_issue_ctrl_decode.sv
// Extracts hazard-relevant fields from one 32-bit instruction word.
module instr_fields_decode
  import hazard_issue_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output fields_t     o_fields
);

  logic [5:0] w_op;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_unused = ^i_instr[10:0];

  always_comb begin
    o_fields = '0;
    case (w_op)
      OP_RTYPE: begin
        o_fields.writes  = 1'b1;
        o_fields.dest    = i_instr[15:11];
        o_fields.rs_used = 1'b1;
        o_fields.rt_used = 1'b1;
      end
      OP_LW, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: begin
        o_fields.writes  = 1'b1;
        o_fields.dest    = i_instr[20:16];
        o_fields.rs_used = 1'b1;
      end
      OP_LUI: begin
        o_fields.writes = 1'b1;
        o_fields.dest   = i_instr[20:16];
      end
      OP_BEQ, OP_BNE: begin
        o_fields.rs_used   = 1'b1;
        o_fields.rt_used   = 1'b1;
        o_fields.is_branch = 1'b1;
      end
      OP_SW: begin
        o_fields.rs_used = 1'b1;
        o_fields.rt_used = 1'b1;
      end
      OP_BGTZ: begin
        o_fields.rs_used   = 1'b1;
        o_fields.is_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_issue_ctrl.sv
// Issue-stage hazard controller: stalls on RAW against the last DEPTH issued words and
// inserts BR_PENALTY bubbles after each branch, counting stall cycles.
module hazard_issue_ctrl
  import hazard_issue_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int BR_PENALTY = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             stall,
  output logic [31:0]      out_instr,
  output logic             out_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state_o
);

  localparam logic [2:0] BR_LOAD = 3'(BR_PENALTY);

  logic [31:0]      r_hist [DEPTH];
  logic [31:0]      r_out_instr;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_stall_count;
  logic [2:0]       r_br_cnt;
  state_e           r_state;

  fields_t          w_cand;
  fields_t          w_hist_f [DEPTH];
  logic [DEPTH-1:0] w_slot_hit;
  logic             w_raw_hit;
  logic             w_stall;
  logic [31:0]      w_issue;
  logic             w_issue_valid;
  logic [2:0]       w_br_cnt_nxt;
  state_e           w_state_nxt;
  logic             w_unused_cand;

  instr_fields_decode u_cand_dec (
    .i_instr  (in_instr),
    .o_fields (w_cand)
  );

  assign w_unused_cand = ^{w_cand.writes, w_cand.dest};

  for (genvar k = 0; k < DEPTH; k++) begin : g_hist
    logic w_unused_slot;

    instr_fields_decode u_hist_dec (
      .i_instr  (r_hist[k]),
      .o_fields (w_hist_f[k])
    );

    assign w_unused_slot = ^{w_hist_f[k].rs_used, w_hist_f[k].rt_used, w_hist_f[k].is_branch};
    assign w_slot_hit[k] = w_hist_f[k].writes &&
                           ((w_cand.rs_used && reg_match(w_hist_f[k].dest, in_instr[25:21])) ||
                            (w_cand.rt_used && reg_match(w_hist_f[k].dest, in_instr[20:16])));
  end

  assign w_raw_hit = in_valid && (|w_slot_hit);

  // Next state and issue word; a branch with a pending RAW waits in RUN before its penalty starts.
  always_comb begin
    w_stall       = 1'b0;
    w_issue       = NOP_INSTR;
    w_issue_valid = 1'b0;
    w_br_cnt_nxt  = r_br_cnt;
    w_state_nxt   = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_raw_hit) begin
          w_stall = 1'b1;
        end else if (in_valid) begin
          w_issue       = in_instr;
          w_issue_valid = 1'b1;
          if (w_cand.is_branch) begin
            w_br_cnt_nxt = BR_LOAD;
            w_state_nxt  = ST_BR_WAIT;
          end
        end
      end
      ST_BR_WAIT: begin
        w_stall      = 1'b1;
        w_br_cnt_nxt = r_br_cnt - 3'd1;
        if (r_br_cnt == 3'd1) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN;
      r_br_cnt <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_br_cnt <= w_br_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_hist[k] <= NOP_INSTR;
      end
      r_out_instr <= NOP_INSTR;
      r_out_valid <= 1'b0;
    end else begin
      r_hist[0] <= w_issue;
      for (int k = 1; k < DEPTH; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
      r_out_instr <= w_issue;
      r_out_valid <= w_issue_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign out_instr   = r_out_instr;
  assign out_valid   = r_out_valid;
  assign stall_count = r_stall_count;
  assign state_o     = r_state;

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Randomized and directed bench for hazard_issue_ctrl, checked every cycle against a
// queue-based model of the issue rules.
module tb_hazard_issue_ctrl;

  localparam int DEPTH      = 3;
  localparam int BR_PENALTY = 3;
  localparam int CNT_W      = 10;  // narrow counter so saturation is reachable in a short run
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam logic [31:0] I_ADD   = 32'h0022_1820;  // add  $3,$1,$2
  localparam logic [31:0] I_SUB   = 32'h0061_2022;  // sub  $4,$3,$1
  localparam logic [31:0] I_LW5   = 32'h8CC5_0000;  // lw   $5,0($6)
  localparam logic [31:0] I_ADDI7 = 32'h2107_0001;  // addi $7,$8,1
  localparam logic [31:0] I_ADD9  = 32'h00A1_4820;  // add  $9,$5,$1
  localparam logic [31:0] I_ADDI0 = 32'h2000_0001;  // addi $0,$0,1
  localparam logic [31:0] I_ADD20 = 32'h0000_1020;  // add  $2,$0,$0
  localparam logic [31:0] I_BEQ   = 32'h1022_0004;  // beq  $1,$2,4
  localparam logic [31:0] I_ADD33 = 32'h0063_1820;  // add  $3,$3,$3

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      in_instr;
  logic             in_valid;
  logic             stall;
  logic [31:0]      out_instr;
  logic             out_valid;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state_o;

  int n_vec  = 0;
  int n_miss = 0;

  hazard_issue_ctrl #(
    .DEPTH      (DEPTH),
    .BR_PENALTY (BR_PENALTY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .stall       (stall),
    .out_instr   (out_instr),
    .out_valid   (out_valid),
    .stall_count (stall_count),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hist[$];
  int          m_br_left;
  logic [31:0] m_out;
  logic        m_valid;
  int          m_cnt;

  // Register written by ins, or -1 when it writes nothing.
  function automatic int m_dest(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:                                    return int'(ins[15:11]);
      6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0F: return int'(ins[20:16]);
      default:                                  return -1;
    endcase
  endfunction

  function automatic bit m_reads(input logic [31:0] ins, input int r);
    int rs = int'(ins[25:21]);
    int rt = int'(ins[20:16]);
    case (ins[31:26])
      6'h00, 6'h04, 6'h05, 6'h2B:                      return (r == rs) || (r == rt);
      6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h07: return (r == rs);
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic bit m_is_branch(input logic [31:0] ins);
    return (ins[31:26] == 6'h04) || (ins[31:26] == 6'h05) || (ins[31:26] == 6'h07);
  endfunction

  function automatic bit m_raw(input logic [31:0] ins, input bit v);
    if (!v) return 1'b0;
    foreach (m_hist[k]) begin
      int d = m_dest(m_hist[k]);
      if (d > 0 && m_reads(ins, d)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall_now();
    return (m_br_left > 0) || m_raw(in_instr, in_valid);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < DEPTH; k++) m_hist.push_back(32'h0);
    m_br_left = 0;
    m_out     = 32'h0;
    m_valid   = 1'b0;
    m_cnt     = 0;
  endtask

  logic [31:0] m_issue;
  logic        m_issue_v;
  bit          m_s;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_s       = m_stall_now();
      m_issue   = 32'h0;
      m_issue_v = 1'b0;
      if (m_br_left > 0) begin
        m_br_left--;
      end else if (!m_s && in_valid) begin
        m_issue   = in_instr;
        m_issue_v = 1'b1;
        if (m_is_branch(in_instr)) m_br_left = BR_PENALTY;
      end
      m_hist.push_front(m_issue);
      void'(m_hist.pop_back());
      m_out   = m_issue;
      m_valid = m_issue_v;
      if (m_s && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("stall",       32'(stall),       32'(m_stall_now()));
    check("out_instr",   out_instr,        m_out);
    check("out_valid",   32'(out_valid),   32'(m_valid));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    check("state_o",     32'(state_o),     (m_br_left > 0) ? 32'd1 : 32'd0);
  end

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; holds ins until accepted, returns just after the accepting edge.
  task automatic present(input logic [31:0] ins, output int stalls);
    bit done = 1'b0;
    stalls   = 0;
    in_instr = ins;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (!done) begin
        @(negedge clk);
        if (stall) stalls++;
        else done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL present_timeout: instr %h not accepted within 64 cycles", ins);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 32'h0;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    in_instr = 32'h0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0F,
            6'h04, 6'h05, 6'h07, 6'h2B};
    op = ops[$urandom_range(0, 11)];
    if (op == 6'h00)
      return {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
              5'($urandom_range(0, 5)), 11'h020};
    return {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 16'($urandom)};
  endfunction

  // ---------------- main sequence ----------------
  int st;
  int st2;

  initial begin
    model_reset();
    reset_n  = 1'b0;
    in_instr = I_ADD;
    in_valid = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_stall", 32'(stall), 32'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_issue_instr", out_instr, I_ADD);
    check("first_issue_valid", 32'(out_valid), 32'd1);
    check("first_issue_count", 32'(stall_count), 32'd0);

    present(I_SUB, st);
    check("raw_d1_stalls", 32'(st), 32'd3);
    check("raw_d1_issue", out_instr, I_SUB);
    check("raw_d1_count", 32'(stall_count), 32'd3);

    pulse_reset();
    present(I_LW5, st);
    present(I_ADDI7, st2);
    check("lw_unrelated_stalls", 32'(st + st2), 32'd0);
    present(I_ADD9, st);
    check("raw_d2_stalls", 32'(st), 32'd2);

    pulse_reset();
    present(I_ADDI0, st);
    present(I_ADD20, st2);
    check("dest0_stalls", 32'(st + st2), 32'd0);
    check("dest0_issue", out_instr, I_ADD20);

    pulse_reset();
    present(I_BEQ, st);
    check("beq_issue_stalls", 32'(st), 32'd0);
    for (int k = 0; k < BR_PENALTY; k++) begin
      @(negedge clk);
      check("br_wait_stall", 32'(stall), 32'd1);
      check("br_wait_state", 32'(state_o), 32'd1);
    end
    @(negedge clk);
    check("br_done_state", 32'(state_o), 32'd0);
    check("br_done_stall", 32'(stall), 32'd0);
    check("br_count", 32'(stall_count), 32'd3);

    present(I_BEQ, st);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_wait_rst_state", 32'(state_o), 32'd0);
    check("mid_wait_rst_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      @(posedge clk);
      #1;
    end

    pulse_reset();
    for (int k = 0; k < 360; k++) present(I_ADD33, st);
    check("sat_count", 32'(stall_count), 32'(CNT_MAX));
    for (int k = 0; k < 10; k++) present(I_ADD33, st);
    check("sat_no_wrap", 32'(stall_count), 32'(CNT_MAX));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_issue_ctrl.md
Name: hazard_issue_ctrl

Overview:
- Issue-side consumer of hazard detection, sitting between IF/ID and ID/EX in the 5-stage MIPS-subset pipeline (no forwarding).
- Keeps its own history of the last DEPTH issued instructions and compares each candidate against it.
- Asserts stall, holds the candidate in IF/ID and drives a NOP bubble into ID/EX until the RAW or branch hazard clears.
- Counts stall cycles for performance reporting.

Parameters:
- DEPTH, 3, number of in-flight issued instructions checked for RAW hazards (1..3).
- BR_PENALTY, 3, bubbles inserted after a branch issues (1..7).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_instr  in  32  candidate instruction from IF/ID.
- in_valid  in  1  in_instr is a real instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- out_instr  out  32  instruction registered into ID/EX.
- out_valid  out  1  out_instr is a real (non-bubble) instruction.
- stall_count  out  CNT_W  saturating count of cycles with stall=1.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Decode per instruction, op=[31:26]:
  - Writers and their destination: R-type (op 0x00) writes rd [15:11]; lw 0x23, addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D, slti 0x0A, lui 0x0F write rt [20:16].
  - Sources: R-type, beq (0x04), bne (0x05) and sw (0x2B) read rs and rt. All other I-types read rs only. lui reads nothing.
  - Branch: beq, bne, bgtz (0x07).
- NOP constant: 32'h0000_0000.
- raw_hit: in_valid, and some hist[k] with k<DEPTH is a writer whose dest is nonzero and equals a source of in_instr.
  - Destination $0 never hazards.
- FSM states: RUN=0, BR_WAIT=1.
- RUN:
  - raw_hit=1: stall=1; shift NOP into hist and out_instr; out_valid=0; stay in RUN.
  - raw_hit=0 and in_valid=1: stall=0; shift in_instr into hist and out_instr; out_valid=1. If in_instr is a branch, load br_cnt=BR_PENALTY and go to BR_WAIT.
  - in_valid=0: stall=0; shift in NOP; out_valid=0.
- BR_WAIT:
  - stall=1 regardless of in_instr or in_valid; shift in NOP; out_valid=0; br_cnt decrements.
  - When br_cnt==1 this cycle, next state is RUN.
  - A branch therefore produces exactly BR_PENALTY stall cycles.
- Timing:
  - Issue latency is 1 cycle: in_instr accepted at edge N appears on out_instr after edge N.
  - hist shifts every cycle, hist[0] <= issued word. Bubbles age hazards out, so a RAW stall self-clears after at most DEPTH cycles.
- Simultaneous events: RAW on a branch candidate is resolved first; the branch issues only when raw_hit=0, then BR_WAIT starts.
- stall_count: +1 on every cycle with stall=1; saturates at all-ones with no wrap.
- Reset (async, any time, including mid-BR_WAIT):
  - hist all NOP, out_instr=0, out_valid=0, br_cnt=0, state=RUN, stall_count=0.
  - stall after reset reflects only raw_hit on the current input, which is 0 because hist is empty.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI, ...);
  - NOP constant;
  - state encoding RUN/BR_WAIT.
- One sub-module, instr_fields_decode: 32-bit instr -> writes, dest[4:0], rs_used, rt_used, is_branch.
  - Instantiated once for the candidate and once per history slot.
- Register comparison reuses the existing 5-bit compare cell.

Test Plan:
- Reset held low for 3 cycles, then released, with in_instr=0x00221820 (add $3,$1,$2), in_valid=1 -> out_instr=0 and stall=0 during reset; after release, out_instr=0x00221820, out_valid=1, stall_count=0.
- Issue 0x00221820, then present 0x00612022 (sub $4,$3,$1) -> stall=1 for exactly 3 cycles with 3 bubbles (out_valid=0); sub issues on cycle 4; stall_count=3.
- Issue lw 0x8CC50000 ($5), then an unrelated instruction, then add using $5 -> 2 stall cycles (lw sits in hist[1]).
- Issue addi $0,$0,1 (0x20000001), then 0x00001020 (add $2,$0,$0) -> no stall; back-to-back issue.
- Issue beq 0x10220004 -> stall=1 for 3 cycles in BR_WAIT, state_o=1; RUN resumes on cycle 4; assert reset_n=0 mid-wait -> state_o=0 and stall_count=0 immediately.
- Force stall_count to all-ones minus 1 via a long RAW chain -> counter saturates at 0xFFFF and never wraps.
